seq_step_fsm: RTL and testbench

SEQ_STEP_FSM -- requirements
Module: seq_step_fsm

---
 rtl/seq_step_pkg.sv | 24 ++
 rtl/seq_tmo_cnt.sv | 45 ++++
 rtl/seq_step_fsm.sv | 152 +++++++++++++++
 tb/tb_seq_step_fsm.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_step_pkg.sv
// Shared types and constants for the step sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_step_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_BADPAT = 2'd1;
   localparam logic [1:0] ERR_TMO    = 2'd2;

   // Width of the per-step cycle counter: clog2(TMO+1), never below one bit.
   function automatic int cnt_width(input int tmo);
      int w;
      w = $clog2(tmo + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/seq_tmo_cnt.sv
// Per-step saturating cycle counter that flags when the next hold would time out.
// Latency: expired reflects the count registered at the previous edge.
// Backpressure: none; clr wins over inc.
//
// Ports: clk, rst (sync, active-high), clr (zero the count), inc (count one
// held cycle), expired (count has reached TMO-1; tied low when TMO==0).
module seq_tmo_cnt
   import seq_step_pkg::*;
#(
   parameter int TMO = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int CW = cnt_width(TMO);

   generate
      if (TMO > 0) begin : g_cnt
         localparam logic [CW-1:0] LAST = CW'(TMO - 1);
         localparam logic [CW-1:0] CMAX = CW'(TMO);

         logic [CW-1:0] cnt;

         always_ff @(posedge clk) begin
            if (rst || clr) begin
               cnt <= '0;
            end else if (inc && (cnt != CMAX)) begin
               cnt <= cnt + 1'b1;
            end
         end

         // One more held cycle at this count means TMO cycles spent in the step.
         assign expired = (cnt == LAST);
      end else begin : g_bypass
         logic unused_ctl;
         assign unused_ctl = ^{clk, rst, clr, inc};
         assign expired    = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/seq_step_fsm.sv
// Step sequencer: checks din walks through a latched list of patterns, with per-step timeout.
// Latency: all outputs registered; din sampled at edge n shows on outputs after edge n.
// Backpressure: none; en=0 aborts a running sequence back to IDLE.
//
// Ports: clk, rst (sync, active-high), en (enable), din[W] (monitored pattern),
// pat[NSTEP*W] (step k at [k*W +: W], latched at start), step_oh[NSTEP] (one-hot
// step while running), busy, done (one-cycle pulse), err, err_code (0 none,
// 1 bad pattern, 2 timeout).
module seq_step_fsm
   import seq_step_pkg::*;
#(
   parameter int W     = 2,
   parameter int NSTEP = 2,
   parameter int TMO   = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [W-1:0]       din,
   input  logic [NSTEP*W-1:0] pat,
   output logic [NSTEP-1:0]   step_oh,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code
);

   localparam int            KW    = $clog2(NSTEP);
   localparam logic [KW-1:0] KLAST = KW'(NSTEP - 1);

   state_t             state;
   state_t             nstate;
   logic [KW-1:0]      k;
   logic [KW-1:0]      nk;
   logic [NSTEP*W-1:0] lpat;
   logic [1:0]         ncode;
   logic               latch;
   logic               cnt_clr;
   logic               cnt_inc;
   logic               expired;
   logic [W-1:0]       cur_p;
   logic [W-1:0]       next_p;

   // Current and following step patterns from the latched copy.
   always_comb begin
      cur_p  = '0;
      next_p = '0;
      for (int i = 0; i < NSTEP; i++) begin
         if (KW'(i) == k) begin
            cur_p = lpat[i*W +: W];
         end
         if ((i > 0) && (KW'(i - 1) == k)) begin
            next_p = lpat[i*W +: W];
         end
      end
   end

   seq_tmo_cnt #(
      .TMO (TMO)
   ) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .expired (expired)
   );

   always_comb begin
      nstate  = state;
      nk      = k;
      ncode   = ERR_NONE;
      latch   = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               if (din == pat[W-1:0]) begin
                  nstate  = RUN;
                  nk      = '0;
                  latch   = 1'b1;
                  cnt_clr = 1'b1;
               end else if (din != '0) begin
                  nstate = ERR;
                  ncode  = ERR_BADPAT;
               end
            end
         end
         RUN: begin
            if (!en) begin
               nstate = IDLE;
            end else if (din == cur_p) begin
               // Hold is checked before advance, so equal neighbouring
               // patterns can only leave the step through the timeout.
               if (expired) begin
                  nstate = ERR;
                  ncode  = ERR_TMO;
               end else begin
                  cnt_inc = 1'b1;
               end
            end else if ((k != KLAST) && (din == next_p)) begin
               nk      = k + 1'b1;
               cnt_clr = 1'b1;
            end else if ((k == KLAST) && (din == '0)) begin
               nstate = DONE;
            end else begin
               nstate = ERR;
               ncode  = ERR_BADPAT;
            end
         end
         DONE: begin
            nstate = IDLE;
         end
         ERR: begin
            // en is ignored here; only an all-zero din releases the error.
            if (din == '0) begin
               nstate = IDLE;
            end else begin
               ncode = err_code;
            end
         end
         default: begin
            nstate = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         k        <= '0;
         lpat     <= '0;
         step_oh  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         state    <= nstate;
         k        <= (nstate == RUN) ? nk : '0;
         if (latch) begin
            lpat <= pat;
         end
         step_oh  <= (nstate == RUN) ? ({{(NSTEP-1){1'b0}}, 1'b1} << nk) : '0;
         busy     <= (nstate == RUN);
         done     <= (nstate == DONE);
         err      <= (nstate == ERR);
         err_code <= ncode;
      end
   end

endmodule

// File: tb/tb_seq_step_fsm.sv
// Directed bench for seq_step_fsm: table of single-cycle vectors plus
// hand-written timeout, no-timeout and pattern-latching sequences.
module tb_seq_step_fsm;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] din;
   logic [3:0] pat;

   logic [1:0] step_oh, step_oh0;
   logic       busy, done, err, busy0, done0, err0;
   logic [1:0] err_code, err_code0;

   int checks = 0;
   int errors = 0;

   // pat1 = 01, pat0 = 11
   localparam logic [3:0] P = 4'b0111;

   seq_step_fsm #(.W(2), .NSTEP(2), .TMO(4)) dut (
      .clk(clk), .rst(rst), .en(en), .din(din), .pat(pat),
      .step_oh(step_oh), .busy(busy), .done(done), .err(err), .err_code(err_code)
   );

   seq_step_fsm #(.W(2), .NSTEP(2), .TMO(0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .din(din), .pat(pat),
      .step_oh(step_oh0), .busy(busy0), .done(done0), .err(err0), .err_code(err_code0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       rst;
      logic       en;
      logic [1:0] din;
      logic [1:0] step_oh;
      logic       busy;
      logic       done;
      logic       err;
      logic [1:0] code;
   } vec_t;

   localparam int NV = 44;
   vec_t vt[NV];

   function automatic vec_t mk(input logic r, input logic e, input logic [1:0] d,
                               input logic [1:0] so, input logic b, input logic dn,
                               input logic er, input logic [1:0] c);
      vec_t v;
      v.rst = r; v.en = e; v.din = d;
      v.step_oh = so; v.busy = b; v.done = dn; v.err = er; v.code = c;
      return v;
   endfunction

   function automatic logic [6:0] pack(input vec_t v);
      return {v.step_oh, v.busy, v.done, v.err, v.code};
   endfunction

   task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got {step_oh,busy,done,err,code}=%b, expected %b", nm, act, exp);
      end
   endtask

   // Drive inputs on the falling edge, then settle just after the next rising edge.
   task automatic cyc(input logic r, input logic e, input logic [1:0] d);
      @(negedge clk);
      rst = r; en = e; din = d;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] o_main();
      return {step_oh, busy, done, err, err_code};
   endfunction

   function automatic logic [6:0] o_zero();
      return {step_oh0, busy0, done0, err0, err_code0};
   endfunction

   initial begin
      rst = 1'b1; en = 1'b0; din = 2'b00; pat = P;

      //             rst en din    oh    b  d  e  code
      vt[0]  = mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 2'd0); // reset
      vt[1]  = mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'd0); // idle, din 0
      vt[2]  = mk(0, 1, 2'b11, 2'b01, 1, 0, 0, 2'd0); // start
      vt[3]  = mk(0, 1, 2'b11, 2'b01, 1, 0, 0, 2'd0); // hold step 0
      vt[4]  = mk(0, 1, 2'b01, 2'b10, 1, 0, 0, 2'd0); // advance
      vt[5]  = mk(0, 1, 2'b00, 2'b00, 0, 1, 0, 2'd0); // done pulse
      vt[6]  = mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'd0); // back to idle
      vt[7]  = mk(0, 1, 2'b10, 2'b00, 0, 0, 1, 2'd1); // bad start
      vt[8]  = mk(0, 1, 2'b10, 2'b00, 0, 0, 1, 2'd1); // err held
      vt[9]  = mk(0, 0, 2'b10, 2'b00, 0, 0, 1, 2'd1); // en ignored in ERR
      vt[10] = mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'd0); // release
      vt[11] = mk(0, 1, 2'b11, 2'b01, 1, 0, 0, 2'd0);
      vt[12] = mk(0, 1, 2'b01, 2'b10, 1, 0, 0, 2'd0);
      vt[13] = mk(0, 1, 2'b10, 2'b00, 0, 0, 1, 2'd1); // bad in step 1
      vt[14] = mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'd0);
      vt[15] = mk(0, 1, 2'b11, 2'b01, 1, 0, 0, 2'd0);
      vt[16] = mk(0, 1, 2'b01, 2'b10, 1, 0, 0, 2'd0);
      vt[17] = mk(0, 0, 2'b01, 2'b00, 0, 0, 0, 2'd0); // abort
      vt[18] = mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'd0);
      vt[19] = mk(0, 1, 2'b11, 2'b01, 1, 0, 0, 2'd0);
      vt[20] = mk(0, 1, 2'b01, 2'b10, 1, 0, 0, 2'd0);
      vt[21] = mk(0, 1, 2'b00, 2'b00, 0, 1, 0, 2'd0); // done
      vt[22] = mk(0, 1, 2'b11, 2'b00, 0, 0, 0, 2'd0); // DONE -> IDLE regardless
      vt[23] = mk(0, 1, 2'b11, 2'b01, 1, 0, 0, 2'd0); // restart from IDLE
      vt[24] = mk(0, 1, 2'b01, 2'b10, 1, 0, 0, 2'd0);
      vt[25] = mk(0, 1, 2'b10, 2'b00, 0, 0, 1, 2'd1); // nonzero at last step
      vt[26] = mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'd0);
      vt[27] = mk(0, 1, 2'b11, 2'b01, 1, 0, 0, 2'd0);
      vt[28] = mk(1, 1, 2'b11, 2'b00, 0, 0, 0, 2'd0); // reset mid-RUN
      vt[29] = mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'd0);
      vt[30] = mk(0, 1, 2'b11, 2'b01, 1, 0, 0, 2'd0);
      vt[31] = mk(0, 1, 2'b00, 2'b00, 0, 0, 1, 2'd1); // zero in step 0 is bad
      vt[32] = mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'd0);
      vt[33] = mk(0, 1, 2'b11, 2'b01, 1, 0, 0, 2'd0);
      vt[34] = mk(0, 1, 2'b01, 2'b10, 1, 0, 0, 2'd0);
      vt[35] = mk(0, 1, 2'b01, 2'b10, 1, 0, 0, 2'd0); // hold step 1
      vt[36] = mk(0, 1, 2'b00, 2'b00, 0, 1, 0, 2'd0);
      vt[37] = mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'd0);
      vt[38] = mk(0, 1, 2'b10, 2'b00, 0, 0, 1, 2'd1);
      vt[39] = mk(1, 1, 2'b10, 2'b00, 0, 0, 0, 2'd0); // reset in ERR
      vt[40] = mk(0, 1, 2'b11, 2'b01, 1, 0, 0, 2'd0);
      vt[41] = mk(0, 1, 2'b01, 2'b10, 1, 0, 0, 2'd0);
      vt[42] = mk(1, 1, 2'b00, 2'b00, 0, 0, 0, 2'd0); // reset drops pending DONE
      vt[43] = mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'd0);

      for (int i = 0; i < NV; i++) begin
         cyc(vt[i].rst, vt[i].en, vt[i].din);
         chk($sformatf("vec%0d", i), o_main(), pack(vt[i]));
      end

      // Timeout in step 0 with TMO=4: error after the 4th cycle in the step.
      cyc(0, 1, 2'b11);
      chk("tmo_start", o_main(), 7'b01_1_0_0_00);
      for (int i = 1; i <= 3; i++) begin
         cyc(0, 1, 2'b11);
         chk($sformatf("tmo_hold%0d", i), o_main(), 7'b01_1_0_0_00);
      end
      cyc(0, 1, 2'b11);
      chk("tmo_fire", o_main(), 7'b00_0_0_1_10);
      cyc(0, 1, 2'b11);
      chk("tmo_held", o_main(), 7'b00_0_0_1_10);
      cyc(0, 1, 2'b00);
      chk("tmo_release", o_main(), 7'b00_0_0_0_00);

      // Counter restarts on advance: 3 holds in each step are fine.
      cyc(0, 1, 2'b11);
      for (int i = 0; i < 3; i++) cyc(0, 1, 2'b11);
      chk("clr_s0_full", o_main(), 7'b01_1_0_0_00);
      cyc(0, 1, 2'b01);
      chk("clr_adv", o_main(), 7'b10_1_0_0_00);
      for (int i = 0; i < 3; i++) cyc(0, 1, 2'b01);
      chk("clr_s1_full", o_main(), 7'b10_1_0_0_00);
      cyc(0, 1, 2'b01);
      chk("clr_s1_tmo", o_main(), 7'b00_0_0_1_10);
      cyc(0, 1, 2'b00);
      chk("clr_release", o_main(), 7'b00_0_0_0_00);

      // TMO=0 instance: hold step 0 for 1000 cycles without error.
      cyc(1, 0, 2'b00);
      cyc(0, 1, 2'b11);
      chk("notmo_start", o_zero(), 7'b01_1_0_0_00);
      for (int i = 0; i < 1000; i++) begin
         cyc(0, 1, 2'b11);
         chk($sformatf("notmo_hold%0d", i), o_zero(), 7'b01_1_0_0_00);
      end
      cyc(1, 0, 2'b00);
      chk("notmo_rst_main", o_main(), 7'b00_0_0_0_00);
      chk("notmo_rst_zero", o_zero(), 7'b00_0_0_0_00);

      // Pattern latching: a change on pat mid-run only affects the next start.
      cyc(0, 1, 2'b00);
      cyc(0, 1, 2'b11);
      chk("lat_start", o_main(), 7'b01_1_0_0_00);
      pat = 4'b1001; // pat1 = 10, pat0 = 01
      cyc(0, 1, 2'b11);
      chk("lat_hold_old", o_main(), 7'b01_1_0_0_00);
      cyc(0, 1, 2'b01);
      chk("lat_adv_old", o_main(), 7'b10_1_0_0_00);
      cyc(0, 1, 2'b00);
      chk("lat_done_old", o_main(), 7'b00_0_1_0_00);
      cyc(0, 1, 2'b00);
      chk("lat_idle", o_main(), 7'b00_0_0_0_00);
      cyc(0, 1, 2'b01);
      chk("lat_start_new", o_main(), 7'b01_1_0_0_00);
      cyc(0, 1, 2'b10);
      chk("lat_adv_new", o_main(), 7'b10_1_0_0_00);
      cyc(0, 1, 2'b00);
      chk("lat_done_new", o_main(), 7'b00_0_1_0_00);
      cyc(0, 1, 2'b00);
      chk("lat_idle_new", o_main(), 7'b00_0_0_0_00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
